// File: rtl/a2d_spi_resp.sv
// SPI responder for an 8-channel 12-bit A2D (CPOL=1, CPHA=1).
// Each frame returns the conversion for the channel addressed by the previous complete frame.
module a2d_spi_resp #(
    parameter logic [2:0]  RESET_CHNL  = 3'd0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic [95:0] ch_data,
    output logic        MISO,
    output logic [15:0] cmd,
    output logic        cmd_vld,
    output logic        frame_err
);

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CH_W       = 12;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned BASE_W     = 7;
    localparam int unsigned SETTLE_W   = $clog2(SYNC_STAGES + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_prev;
    logic                   r_sclk_prev;
    logic [SETTLE_W-1:0]    r_settle;
    logic                   r_armed;

    // FSM and datapath state
    state_t            r_state;
    logic [15:0]       r_tx_shft;
    logic [15:0]       r_rx_shft;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [2:0]        r_chnl_ptr;
    logic [15:0]       r_cmd;
    logic              r_cmd_vld;
    logic              r_frame_err;
    logic              r_miso;

    // Next-state values
    state_t            w_state_nxt;
    logic [15:0]       w_tx_nxt;
    logic [15:0]       w_rx_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [2:0]        w_chnl_nxt;
    logic [15:0]       w_cmd_nxt;
    logic              w_cmd_vld_nxt;
    logic              w_frame_err_nxt;
    logic              w_miso_nxt;

    logic              w_ss;
    logic              w_sclk;
    logic              w_mosi;
    logic              w_ss_fall;
    logic              w_ss_rise;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic [BASE_W-1:0] w_ch_base;
    logic [CH_W-1:0]   w_ch_word;

    assign w_ss   = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // A fall is only trusted once SS_n has been seen high after reset, so a
    // reset in the middle of a frame cannot fake a frame start.
    assign w_ss_fall   = r_armed & r_ss_prev & ~w_ss;
    assign w_ss_rise   = w_ss & ~r_ss_prev;
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;

    assign w_ch_base = BASE_W'(r_chnl_ptr) * BASE_W'(CH_W);
    assign w_ch_word = ch_data[w_ch_base +: CH_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '1;
            r_mosi_sync <= '0;
            r_ss_prev   <= 1'b1;
            r_sclk_prev <= 1'b1;
            r_settle    <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_prev   <= w_ss;
            r_sclk_prev <= w_sclk;
            if (r_settle != SETTLE_W'(SYNC_STAGES)) begin
                r_settle <= r_settle + 1'b1;
            end else if (w_ss) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tx_shft   <= '0;
            r_rx_shft   <= '0;
            r_bit_cnt   <= '0;
            r_chnl_ptr  <= RESET_CHNL;
            r_cmd       <= '0;
            r_cmd_vld   <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_shft   <= w_tx_nxt;
            r_rx_shft   <= w_rx_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_chnl_ptr  <= w_chnl_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cmd_vld   <= w_cmd_vld_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_miso      <= w_miso_nxt;
        end
    end

    // Frame sequencing; SS_rise takes priority over any SCLK edge in the same clk
    always_comb begin
        w_state_nxt     = r_state;
        w_tx_nxt        = r_tx_shft;
        w_rx_nxt        = r_rx_shft;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_chnl_nxt      = r_chnl_ptr;
        w_cmd_nxt       = r_cmd;
        w_cmd_vld_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_tx_nxt      = {4'b0000, w_ch_word};
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_ss_rise) begin
                    if (r_bit_cnt == CNT_W'(FRAME_BITS)) begin
                        w_cmd_nxt     = r_rx_shft;
                        w_chnl_nxt    = r_rx_shft[13:11];
                        w_cmd_vld_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end else if (w_ss_fall) begin
                    w_tx_nxt      = {4'b0000, w_ch_word};
                    w_bit_cnt_nxt = '0;
                end else if (w_sclk_rise) begin
                    w_rx_nxt = {r_rx_shft[14:0], w_mosi};
                    if (r_bit_cnt != '1) begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                    w_tx_nxt = {r_tx_shft[14:0], 1'b0};
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_miso_nxt = (w_state_nxt == ACTIVE) ? w_tx_nxt[15] : 1'b0;
    end

    assign MISO      = r_miso;
    assign cmd       = r_cmd;
    assign cmd_vld   = r_cmd_vld;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: directed vector table, mid-frame corner sequences and
// randomized frames checked against a channel-pointer reference model.
module tb_a2d_spi_resp;

    localparam int SYNC = 2;
    localparam int HP   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [95:0] ch_data;
    logic        MISO;
    logic [15:0] cmd;
    logic        cmd_vld;
    logic        frame_err;

    a2d_spi_resp #(
        .RESET_CHNL (3'd0),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .ch_data  (ch_data),
        .MISO     (MISO),
        .cmd      (cmd),
        .cmd_vld  (cmd_vld),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;
    int last_vld_cyc = 0;
    int ss_rise_cyc  = 0;

    logic [11:0] ch_mem [8];
    int          m_ptr;
    logic [15:0] m_cmd;

    typedef struct {
        int          set_idx;
        logic [11:0] set_val;
        logic [15:0] mosi;
        int          nbits;
        logic [15:0] exp_resp;
        logic [15:0] exp_cmd;
        int          exp_vld;
        int          exp_err;
    } vec_t;

    vec_t vecs [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_vld) begin
            vld_cnt++;
            last_vld_cyc = cyc;
        end
        if (frame_err) err_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int idx, input logic [11:0] v);
        ch_mem[idx] = v;
        ch_data[idx*12 +: 12] = v;
    endtask

    // hook_kind: 0 none, 1 change channel hook_ch to hook_val, 2 pulse rst
    task automatic run_frame(input logic [15:0] mosi_w, input int nbits, input int hook_kind,
                             input int hook_bit, input int hook_ch, input logic [11:0] hook_val,
                             output logic [15:0] miso_w);
        logic [15:0] sh;
        int ncap;
        sh     = mosi_w;
        miso_w = '0;
        ncap   = (nbits < 16) ? nbits : 16;
        SS_n   = 1'b0;
        wait_clks(HP);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = sh[15];
            sh   = {sh[14:0], 1'b0};
            wait_clks(HP);
            if (i < 16) miso_w = {miso_w[14:0], MISO};
            SCLK = 1'b1;
            wait_clks(HP);
            if (i == hook_bit && hook_kind == 1) set_ch(hook_ch, hook_val);
            if (i == hook_bit && hook_kind == 2) begin
                rst = 1'b1;
                wait_clks(2);
                chk("midrst_miso", 32'(MISO), 32'(0));
                chk("midrst_cmd", 32'(cmd), 32'(0));
                rst = 1'b0;
            end
        end
        if (ncap < 16) miso_w = miso_w << (16 - ncap);
        SS_n = 1'b1;
        ss_rise_cyc = cyc;
        wait_clks(10);
    endtask

    task automatic frame_and_check(input string tag, input logic [15:0] mosi_w, input int nbits,
                                   input int ncmp, input logic [15:0] exp_resp,
                                   input logic [15:0] exp_cmd, input int exp_vld, input int exp_err,
                                   input int hook_kind, input int hook_bit, input int hook_ch,
                                   input logic [11:0] hook_val);
        logic [15:0] got;
        logic [15:0] mask;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        run_frame(mosi_w, nbits, hook_kind, hook_bit, hook_ch, hook_val, got);
        mask = 16'hFFFF;
        mask = mask << (16 - ncmp);
        if (ncmp > 0) chk($sformatf("%s_resp", tag), 32'(got & mask), 32'(exp_resp & mask));
        chk($sformatf("%s_cmd", tag), 32'(cmd), 32'(exp_cmd));
        chk($sformatf("%s_vld", tag), 32'(vld_cnt - v0), 32'(exp_vld));
        chk($sformatf("%s_err", tag), 32'(err_cnt - e0), 32'(exp_err));
        if (exp_vld == 1 && vld_cnt != v0)
            chk($sformatf("%s_lat", tag), 32'(last_vld_cyc - ss_rise_cyc), 32'(SYNC + 1));
    endtask

    initial begin
        logic [15:0] mosi_r;
        logic [15:0] exp_r;
        int          nb, hk, hb;

        vecs[0] = '{0, 12'hABC, 16'h0000, 16, 16'h0ABC, 16'h0000, 1, 0};
        vecs[1] = '{5, 12'h555, 16'h2800, 16, 16'h0ABC, 16'h2800, 1, 0};
        vecs[2] = '{6, 12'h7FF, 16'h3000, 16, 16'h0555, 16'h3000, 1, 0};
        vecs[3] = '{6, 12'h7FF, 16'h0000, 16, 16'h07FF, 16'h0000, 1, 0};
        vecs[4] = '{3, 12'h333, 16'h1800,  9, 16'h0ABC, 16'h0000, 0, 1};
        vecs[5] = '{4, 12'h444, 16'h2000, 16, 16'h0ABC, 16'h2000, 1, 0};
        vecs[6] = '{1, 12'h111, 16'h0800, 17, 16'h0444, 16'h2000, 0, 1};
        vecs[7] = '{2, 12'h222, 16'h0000, 16, 16'h0444, 16'h0000, 1, 0};

        rst     = 1'b1;
        SS_n    = 1'b1;
        SCLK    = 1'b1;
        MOSI    = 1'b0;
        ch_data = '0;
        for (int n = 0; n < 8; n++) set_ch(n, 12'(n * 273));
        wait_clks(2);
        chk("rst_miso", 32'(MISO), 32'(0));
        chk("rst_cmd", 32'(cmd), 32'(0));
        chk("rst_cmd_vld", 32'(cmd_vld), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        rst = 1'b0;
        wait_clks(6);

        for (int v = 0; v < 8; v++) begin
            set_ch(vecs[v].set_idx, vecs[v].set_val);
            frame_and_check($sformatf("vec%0d", v), vecs[v].mosi, vecs[v].nbits,
                            (vecs[v].nbits < 16) ? vecs[v].nbits : 16,
                            vecs[v].exp_resp, vecs[v].exp_cmd, vecs[v].exp_vld,
                            vecs[v].exp_err, 0, 0, 0, 12'h000);
        end

        // Snapshot: ch0 changes after bit 3, frame keeps the old value
        set_ch(0, 12'h123);
        frame_and_check("snap", 16'h0000, 16, 16, 16'h0123, 16'h0000, 1, 0, 1, 3, 0, 12'hFFF);
        frame_and_check("snap_next", 16'h2800, 16, 16, 16'h0FFF, 16'h2800, 1, 0, 0, 0, 0, 12'h000);

        // Reset after 8 bits with pointer at 5; the rest of that frame is ignored
        set_ch(5, 12'h5A5);
        set_ch(0, 12'h0C3);
        frame_and_check("rstmid", 16'h1000, 16, 8, 16'h05A5, 16'h0000, 0, 0, 2, 7, 0, 12'h000);
        frame_and_check("rstmid_next", 16'h0000, 16, 16, 16'h00C3, 16'h0000, 1, 0, 0, 0, 0, 12'h000);

        m_ptr = 0;
        m_cmd = 16'h0000;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) set_ch(int'($urandom_range(0, 7)), 12'($urandom));
            mosi_r = 16'($urandom);
            nb     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            hk     = ($urandom_range(0, 2) == 0) ? 1 : 0;
            hb     = int'($urandom_range(0, 15));
            exp_r  = {4'h0, ch_mem[m_ptr]};
            if (nb == 16) begin
                frame_and_check($sformatf("rnd%0d", k), mosi_r, nb, 16, exp_r, mosi_r, 1, 0,
                                hk, hb, m_ptr, 12'($urandom));
                m_cmd = mosi_r;
                m_ptr = int'(mosi_r[13:11]);
            end else begin
                frame_and_check($sformatf("rnd%0d", k), mosi_r, nb, (nb < 16) ? nb : 16, exp_r,
                                m_cmd, 0, 1, hk, hb, m_ptr, 12'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
